// File: rtl/matrix_vector_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_vector_stream_loader
// Description : Collects a valid/ready stream of N*N matrix elements
//               (row-major) followed by N vector elements, packs them into
//               flat buses, starts the matrix-vector multiplier with a
//               one-cycle mv_ena pulse and holds the buses until mv_done.
//               Frame boundaries are checked against in_last.
//               Optional macro MVSL_VECTOR_REUSE_EN adds reuse_vec: a frame
//               flagged on its first element carries only the matrix and
//               keeps the previous vector.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_vector_stream_loader #(
    parameter int N     = 3,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
`ifdef MVSL_VECTOR_REUSE_EN
    input  logic                     reuse_vec,
`endif
    output logic                     in_ready,
    output logic [N*N*WIDTH-1:0]     matrix_a,
    output logic [N*WIDTH-1:0]       vector_b,
    output logic                     mv_ena,
    input  logic                     mv_done,
    output logic                     busy,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);

    localparam int CNT_W = $clog2(N*N+N);

    // Index of the last element of a full-length frame
    localparam logic [CNT_W-1:0] c_last_full = CNT_W'(N*N+N-1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_idx;
    logic [N*N*WIDTH-1:0]    r_matrix_a;
    logic [N*WIDTH-1:0]      r_vector_b;
    logic                    r_mv_ena;
    logic                    r_busy;
    logic                    r_frame_err;
    logic [15:0]             r_frame_cnt;

    logic                    w_xfer;
    logic                    w_first;
    logic                    w_final;
    logic                    w_launch;
    logic                    w_err;

    assign w_xfer  = in_valid && in_ready;
    assign w_first = (r_idx == '0);

`ifdef MVSL_VECTOR_REUSE_EN
    // Matrix-only frames end after N*N elements
    localparam logic [CNT_W-1:0] c_last_short = CNT_W'(N*N-1);
    logic r_reuse;
    logic w_reuse;

    // The reuse flag is live on the first element and remembered afterwards
    assign w_reuse = w_first ? reuse_vec : r_reuse;
    assign w_final = w_reuse ? (r_idx == c_last_short) : (r_idx == c_last_full);

    // Remember the reuse flag seen with the first element of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reuse <= 1'b0;
        end else if (w_xfer && w_first) begin
            r_reuse <= reuse_vec;
        end
    end
`else
    assign w_final = (r_idx == c_last_full);
`endif

    // A good frame ends exactly on the final index with in_last; any
    // disagreement between position and in_last is a framing error.
    assign w_launch = w_xfer && w_final && in_last;
    assign w_err    = w_xfer && (w_final != in_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = !rst;
                if (w_launch) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mv_done) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Element capture, index tracking, launch pulse and frame bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_matrix_a  <= '0;
            r_vector_b  <= '0;
            r_mv_ena    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_mv_ena    <= w_launch;
            r_frame_err <= w_err;
            if (w_xfer) begin
                for (int i = 0; i < N*N; i++) begin
                    if (r_idx == CNT_W'(i)) begin
                        r_matrix_a[i*WIDTH +: WIDTH] <= in_data;
                    end
                end
                for (int j = 0; j < N; j++) begin
                    if (r_idx == CNT_W'(N*N+j)) begin
                        r_vector_b[j*WIDTH +: WIDTH] <= in_data;
                    end
                end
                // Any frame end, good or bad, restarts at element 0
                if (in_last || w_final) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + CNT_W'(1);
                end
            end
            if (w_launch) begin
                r_busy      <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if ((r_state == S_WAIT) && mv_done) begin
                r_busy      <= 1'b0;
            end
        end
    end

    assign matrix_a  = r_matrix_a;
    assign vector_b  = r_vector_b;
    assign mv_ena    = r_mv_ena;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_matrix_vector_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_vector_stream_loader
// Description : Self-checking bench for matrix_vector_stream_loader with a
//               behavioural model of the expected matrix/vector contents and
//               the expected number of launched frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_vector_stream_loader;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NE = N*N+N;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic signed [W-1:0]   in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_last = 1'b0;
    logic                  in_ready;
    logic [N*N*W-1:0]      matrix_a;
    logic [N*W-1:0]        vector_b;
    logic                  mv_ena;
    logic                  mv_done = 1'b0;
    logic                  busy;
    logic                  frame_err;
    logic [15:0]           frame_cnt;
`ifdef MVSL_VECTOR_REUSE_EN
    logic                  reuse_vec = 1'b0;
`endif

    always #5 clk = ~clk;

    matrix_vector_stream_loader #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
`ifdef MVSL_VECTOR_REUSE_EN
        .reuse_vec (reuse_vec),
`endif
        .in_ready  (in_ready),
        .matrix_a  (matrix_a),
        .vector_b  (vector_b),
        .mv_ena    (mv_ena),
        .mv_done   (mv_done),
        .busy      (busy),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ena_cnt  = 0;
    int err_cnt  = 0;

    // Behavioural model: element values by matrix/vector position
    logic [W-1:0] mdl_m [N*N];
    logic [W-1:0] mdl_v [N];
    int           mdl_frames = 0;
    logic [W-1:0] frame_data [NE];

    // Pulse counters for mv_ena and frame_err
    always @(negedge clk) begin
        if (mv_ena)    ena_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*N*W-1:0] exp_matrix();
        logic [N*N*W-1:0] r;
        r = '0;
        for (int row = 0; row < N; row++)
            for (int col = 0; col < N; col++)
                r[(row*N+col)*W +: W] = mdl_m[row*N+col];
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_vector();
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = mdl_v[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N*N; k++) mdl_m[k] = '0;
        for (int k = 0; k < N; k++)   mdl_v[k] = '0;
        mdl_frames = 0;
    endtask

    // Offer one element; returns after the accepting edge
    task automatic send(input logic [W-1:0] d, input logic last, input int pos, input int gap);
        int k;
        repeat ($urandom_range(0, gap)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready=%0b pos=%0d required in_ready=1", in_ready, pos);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (pos < N*N) mdl_m[pos] = d;
            else           mdl_v[pos-N*N] = d;
        end
    endtask

    task automatic send_frame(input int len, input int last_at, input int gap);
        for (int p = 0; p < len; p++) send(frame_data[p], p == last_at, p, gap);
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        mv_done = 1'b1;
        @(posedge clk);
        #1;
        mv_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL done_release: busy=%0b in_ready=%0b required busy=0 in_ready=1", busy, in_ready);
        else n_pass++;
    endtask

    // Send a complete random frame and check the launch
    task automatic test_launch(input bit reuse, input int gap);
        int len;
        int e0;
        len = reuse ? N*N : NE;
        for (int p = 0; p < NE; p++) frame_data[p] = W'($urandom);
`ifdef MVSL_VECTOR_REUSE_EN
        reuse_vec = reuse;
`endif
        e0 = ena_cnt;
        send_frame(len, len-1, gap);
`ifdef MVSL_VECTOR_REUSE_EN
        reuse_vec = 1'b0;
`endif
        mdl_frames++;
        n_checks++;
        if (mv_ena !== 1'b1 || busy !== 1'b1 || frame_cnt !== 16'(mdl_frames))
            $display("FAIL launch: mv_ena=%0b busy=%0b frame_cnt=%0d required 1 1 %0d",
                     mv_ena, busy, frame_cnt, mdl_frames);
        else n_pass++;
        n_checks++;
        if (matrix_a !== exp_matrix() || vector_b !== exp_vector())
            $display("FAIL launch_buses: a=%h b=%h required a=%h b=%h",
                     matrix_a, vector_b, exp_matrix(), exp_vector());
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (mv_ena !== 1'b0 || ena_cnt - e0 != 1 || in_ready !== 1'b0)
            $display("FAIL ena_pulse: mv_ena=%0b pulses=%0d in_ready=%0b required 0 1 0",
                     mv_ena, ena_cnt - e0, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if (in_ready !== 1'b0 || matrix_a !== '0 || vector_b !== '0 || mv_ena !== 1'b0 ||
            busy !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd0)
            $display("FAIL reset_state: rdy=%0b a=%h b=%h ena=%0b busy=%0b err=%0b cnt=%0d required all 0",
                     in_ready, matrix_a, vector_b, mv_ena, busy, frame_err, frame_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int e0;
        for (int p = 0; p < N*N; p++) frame_data[p] = W'(p+1);
        frame_data[9]  = 8'h01;
        frame_data[10] = 8'h00;
        frame_data[11] = 8'hFF;
        e0 = ena_cnt;
        send_frame(NE, NE-1, 0);
        mdl_frames++;
        n_checks++;
        if (matrix_a !== 72'h090807060504030201 || vector_b !== 24'hFF0001)
            $display("FAIL basic_buses: a=%h b=%h required a=090807060504030201 b=ff0001", matrix_a, vector_b);
        else n_pass++;
        n_checks++;
        if (mv_ena !== 1'b1 || busy !== 1'b1 || frame_cnt !== 16'd1)
            $display("FAIL basic_launch: ena=%0b busy=%0b cnt=%0d required 1 1 1", mv_ena, busy, frame_cnt);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (mv_ena !== 1'b0 || ena_cnt - e0 != 1)
            $display("FAIL basic_pulse: ena=%0b pulses=%0d required 0 1", mv_ena, ena_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_wait_hold();
        int bad;
        bad = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = W'($urandom);
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1 ||
                matrix_a !== exp_matrix() || vector_b !== exp_vector()) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL wait_hold: bad_cycles=%0d required 0", bad);
        else n_pass++;
        mv_done = 1'b1;
        @(posedge clk);
        #1;
        mv_done  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || matrix_a !== exp_matrix() || vector_b !== exp_vector())
            $display("FAIL wait_release: busy=%0b in_ready=%0b required busy=0 in_ready=1", busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_done_in_fill();
        @(negedge clk);
        mv_done = 1'b1;
        @(posedge clk);
        #1;
        mv_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'(mdl_frames))
            $display("FAIL done_in_fill: busy=%0b in_ready=%0b cnt=%0d required 0 1 %0d",
                     busy, in_ready, frame_cnt, mdl_frames);
        else n_pass++;
    endtask

    task automatic test_early_last();
        int e0;
        int r0;
        for (int p = 0; p < NE; p++) frame_data[p] = W'($urandom);
        e0 = ena_cnt;
        r0 = err_cnt;
        send_frame(7, 6, 1);
        n_checks++;
        if (frame_err !== 1'b1) $display("FAIL early_last_err: frame_err=%0b required 1", frame_err);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - r0 != 1 || ena_cnt - e0 != 0 || frame_cnt !== 16'(mdl_frames) ||
            busy !== 1'b0 || in_ready !== 1'b1 || matrix_a !== exp_matrix())
            $display("FAIL early_last_after: errs=%0d enas=%0d cnt=%0d busy=%0b a=%h required 1 0 %0d 0 %h",
                     err_cnt - r0, ena_cnt - e0, frame_cnt, busy, matrix_a, mdl_frames, exp_matrix());
        else n_pass++;
        test_launch(1'b0, 0);
        pulse_done(2);
    endtask

    task automatic test_missing_last();
        int e0;
        int r0;
        for (int p = 0; p < NE; p++) frame_data[p] = W'($urandom);
        e0 = ena_cnt;
        r0 = err_cnt;
        send_frame(NE, -1, 0);
        n_checks++;
        if (frame_err !== 1'b1 || mv_ena !== 1'b0)
            $display("FAIL missing_last_err: frame_err=%0b mv_ena=%0b required 1 0", frame_err, mv_ena);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - r0 != 1 || ena_cnt - e0 != 0 || frame_cnt !== 16'(mdl_frames) || in_ready !== 1'b1)
            $display("FAIL missing_last_after: errs=%0d enas=%0d cnt=%0d in_ready=%0b required 1 0 %0d 1",
                     err_cnt - r0, ena_cnt - e0, frame_cnt, in_ready, mdl_frames);
        else n_pass++;
        test_launch(1'b0, 1);
        pulse_done(0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL %s_rdy_in_rst: in_ready=%0b required 0", tag, in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if (matrix_a !== '0 || vector_b !== '0 || mv_ena !== 1'b0 || busy !== 1'b0 ||
            frame_err !== 1'b0 || frame_cnt !== 16'd0)
            $display("FAIL %s_clear: a=%h b=%h ena=%0b busy=%0b err=%0b cnt=%0d required all 0",
                     tag, matrix_a, vector_b, mv_ena, busy, frame_err, frame_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s_rdy_after: in_ready=%0b required 1", tag, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midway();
        test_launch(1'b0, 0);
        apply_reset("rst_wait");
        for (int p = 0; p < NE; p++) frame_data[p] = W'($urandom);
        send_frame(5, -1, 0);
        apply_reset("rst_fill");
        test_launch(1'b0, 2);
        pulse_done(1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            test_launch(1'b0, f % 3);
            pulse_done($urandom_range(0, 6));
        end
    endtask

`ifdef MVSL_VECTOR_REUSE_EN
    task automatic test_reuse();
        logic [N*W-1:0] v0;
        test_launch(1'b0, 0);
        v0 = vector_b;
        pulse_done(1);
        test_launch(1'b1, 0);
        n_checks++;
        if (vector_b !== v0) $display("FAIL reuse_vector: b=%h required %h", vector_b, v0);
        else n_pass++;
        pulse_done(0);
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_wait_hold();
        test_done_in_fill();
        test_early_last();
        test_missing_last();
        test_reset_midway();
        test_random_frames();
`ifdef MVSL_VECTOR_REUSE_EN
        test_reuse();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
